// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher: one round per clock, key schedule run forward then unwound.
// Define AES_DEC_KEYCACHE_EN to cache the last key and its rk10, so a repeated key skips EXPAND.

module aes_sbox_lane #(
  parameter bit INV = 1'b0
) (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); zero maps to zero as AES requires
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq, acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  generate
    if (INV) begin : g_inv
      logic [7:0] y;
      assign y    = {din[6:0], din[7]} ^ {din[4:0], din[7:5]} ^ {din[1:0], din[7:2]} ^ 8'h05;
      assign dout = ginv(y);
    end else begin : g_fwd
      logic [7:0] v;
      assign v    = ginv(din);
      assign dout = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    end
  endgenerate
endmodule

module aes_inv_mix_col (
  input  logic [31:0] col,
  output logic [31:0] mixed
);
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return (c[0] ? a : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = col;
  assign mixed = {mul(a0, 4'he) ^ mul(a1, 4'hb) ^ mul(a2, 4'hd) ^ mul(a3, 4'h9),
                  mul(a0, 4'h9) ^ mul(a1, 4'he) ^ mul(a2, 4'hb) ^ mul(a3, 4'hd),
                  mul(a0, 4'hd) ^ mul(a1, 4'h9) ^ mul(a2, 4'he) ^ mul(a3, 4'hb),
                  mul(a0, 4'hb) ^ mul(a1, 4'hd) ^ mul(a2, 4'h9) ^ mul(a3, 4'he)};
endmodule

module aes128_decrypt_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic [127:0] plaintext
);
  typedef enum logic [1:0] {IDLE, EXPAND, ROUND} fsm_t;

  fsm_t         fsm;
  logic [127:0] st, rk;
  logic [7:0]   rcon;
  logic [3:0]   cnt;

  // Key schedule: one shared SubWord, fed w3 going forward and the recovered w3 going back
  logic [31:0]  w0, w1, w2, w3, sub_in, rot, sub_out;
  logic [31:0]  n0, n1, n2, n3, p0, p1, p2, p3;
  logic [127:0] rk_next, rk_prev;

  assign {w0, w1, w2, w3} = rk;
  assign sub_in = (fsm == ROUND) ? (w3 ^ w2) : w3;
  assign rot    = {sub_in[23:0], sub_in[31:24]};

  generate
    for (genvar j = 0; j < 4; j++) begin : g_ks
      aes_sbox_lane #(.INV(1'b0)) u_sbox (.din(rot[8*j +: 8]), .dout(sub_out[8*j +: 8]));
    end
  endgenerate

  assign n0      = w0 ^ sub_out ^ {rcon, 24'h0};
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign rk_next = {n0, n1, n2, n3};
  assign p3      = w3 ^ w2;
  assign p2      = w2 ^ w1;
  assign p1      = w1 ^ w0;
  assign p0      = w0 ^ sub_out ^ {rcon, 24'h0};
  assign rk_prev = {p0, p1, p2, p3};

  // Round datapath; byte i of the block lives in sb[15-i], state[r][c] = byte r+4c
  logic [15:0][7:0] sb, isb;
  logic [127:0]     ark, imc, round_out;

  assign sb = st;

  generate
    for (genvar i = 0; i < 16; i++) begin : g_lane
      localparam int R   = i % 4;
      localparam int C   = i / 4;
      localparam int SRC = R + 4 * ((C - R + 4) % 4);
      aes_sbox_lane #(.INV(1'b1)) u_isb (.din(sb[15-SRC]), .dout(isb[15-i]));
    end
    for (genvar c = 0; c < 4; c++) begin : g_col
      aes_inv_mix_col u_imc (.col(ark[127-32*c -: 32]), .mixed(imc[127-32*c -: 32]));
    end
  endgenerate

  assign ark       = isb ^ rk_prev;
  assign round_out = (cnt == 4'd9) ? ark : imc;

  logic [7:0] rcon_mul, rcon_div;
  logic [8:0] rcon_red;
  assign rcon_mul = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
  assign rcon_red = {1'b0, rcon} ^ (rcon[0] ? 9'h11b : 9'h000);
  assign rcon_div = rcon_red[8:1];

`ifdef AES_DEC_KEYCACHE_EN
  logic         cache_vld, cache_hit;
  logic [127:0] cache_key, cache_rk10, op_key;
  assign cache_hit = cache_vld && (key == cache_key);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      st        <= '0;
      rk        <= '0;
      rcon      <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      plaintext <= '0;
`ifdef AES_DEC_KEYCACHE_EN
      cache_vld  <= 1'b0;
      cache_key  <= '0;
      cache_rk10 <= '0;
      op_key     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
`ifdef AES_DEC_KEYCACHE_EN
            // keep the accepted key: the live input may change during EXPAND
            op_key <= key;
            if (cache_hit) begin
              st   <= ciphertext ^ cache_rk10;
              rk   <= cache_rk10;
              rcon <= 8'h36;
              fsm  <= ROUND;
            end else begin
              st   <= ciphertext;
              rk   <= key;
              rcon <= 8'h01;
              fsm  <= EXPAND;
            end
`else
            st   <= ciphertext;
            rk   <= key;
            rcon <= 8'h01;
            fsm  <= EXPAND;
`endif
          end
        end
        EXPAND: begin
          rk <= rk_next;
          if (cnt == 4'd9) begin
            st  <= st ^ rk_next;
            cnt <= '0;
            fsm <= ROUND;
`ifdef AES_DEC_KEYCACHE_EN
            cache_vld  <= 1'b1;
            cache_key  <= op_key;
            cache_rk10 <= rk_next;
`endif
          end else begin
            cnt  <= cnt + 4'd1;
            rcon <= rcon_mul;
          end
        end
        ROUND: begin
          st   <= round_out;
          rk   <= rk_prev;
          rcon <= rcon_div;
          if (cnt == 4'd9) begin
            plaintext <= round_out;
            done      <= 1'b1;
            busy      <= 1'b0;
            cnt       <= '0;
            fsm       <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Scoreboard bench for aes128_decrypt_iter: FIPS vectors, handshake, reset, key cache, round trip.
module tb_aes128_decrypt_iter;
  logic         clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [127:0] ciphertext = '0, key = '0;
  logic         busy, done;
  logic [127:0] plaintext;

  aes128_decrypt_iter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ciphertext(ciphertext), .key(key),
    .busy(busy), .done(done), .plaintext(plaintext)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] K_C1    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] RK10_C1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K_B     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK10_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  typedef struct { logic [127:0] pt; int lat; } exp_t;
  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  logic [7:0] sbox [256];
  logic tc_vld = 1'b0;
  logic [127:0] tc_key = '0;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // S-box generated by walking the multiplicative group with generator 3
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end
    sbox[0] = 8'h63;
  endtask

  // Forward AES-128 reference, used to make ciphertexts for the round trip
  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int i = 0; i < 16; i++) s[i] = t[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Call at a negedge; returns at the negedge after the accepting edge. Pushes the expectation.
  task automatic start_op(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] pt);
    exp_t e;
    key = k;
    ciphertext = ct;
    start = 1'b1;
    e.pt = pt;
    e.lat = 20;
`ifdef AES_DEC_KEYCACHE_EN
    if (tc_vld && tc_key == k) e.lat = 10;
    tc_vld = 1'b1;
    tc_key = k;
`endif
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    key = rnd128();
    ciphertext = rnd128();
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    tc_vld = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    n_chk++; if (plaintext !== '0) begin n_fail++; $display("FAIL rst_pt: got %h want 0", plaintext); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vector(input string nm, input logic [127:0] k, input logic [127:0] ct,
                             input logic [127:0] pt, input logic [127:0] rk10);
    exp_t e;
    int lat;
    start_op(k, ct, pt);
    repeat (10) @(negedge clk);
    if (exp_q[0].lat == 20) begin
      n_chk++; if (dut.rk !== rk10) begin n_fail++; $display("FAIL %s_rk10: got %h want %h", nm, dut.rk, rk10); end
    end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy: got %b want 1", nm, busy); end
    wait_done(lat);
    lat += 10;
    e = exp_q.pop_front();
    n_chk++; if (done !== 1'b1 || lat != e.lat) begin n_fail++; $display("FAIL %s_lat: got %0d want %0d", nm, lat, e.lat); end
    n_chk++; if (plaintext !== e.pt) begin n_fail++; $display("FAIL %s_pt: got %h want %h", nm, plaintext, e.pt); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_done: got %b want 0", nm, busy); end
    @(negedge clk);
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s_pulse: done got %b want 0", nm, done); end
    n_chk++; if (plaintext !== e.pt) begin n_fail++; $display("FAIL %s_hold: got %h want %h", nm, plaintext, e.pt); end
  endtask

  task automatic test_handshake();
    exp_t e;
    int lat;
    logic [127:0] k, p;
    k = rnd128();
    p = rnd128();
    start_op(k, aes_enc(k, p), p);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (lat == 2 || lat == 7 || lat == 14) begin
        start = 1'b1;
        key = rnd128();
        ciphertext = rnd128();
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
      if (done !== 1'b1) begin
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hs_busy: cycle %0d got %b want 1", lat, busy); end
      end
    end
    start = 1'b0;
    e = exp_q.pop_front();
    n_chk++; if (done !== 1'b1 || lat != e.lat) begin n_fail++; $display("FAIL hs_lat: got %0d want %0d", lat, e.lat); end
    n_chk++; if (plaintext !== e.pt) begin n_fail++; $display("FAIL hs_pt: got %h want %h", plaintext, e.pt); end
    start_op(K_C1, CT_C1, PT_C1);
    n_chk++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: busy %b done %b want 1 0", busy, done); end
    wait_done(lat);
    e = exp_q.pop_front();
    n_chk++; if (done !== 1'b1 || lat != e.lat) begin n_fail++; $display("FAIL b2b_lat: got %0d want %0d", lat, e.lat); end
    n_chk++; if (plaintext !== e.pt) begin n_fail++; $display("FAIL b2b_pt: got %h want %h", plaintext, e.pt); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int lat;
    logic [127:0] k, p;
    k = rnd128();
    p = rnd128();
    @(negedge clk);
    start_op(k, aes_enc(k, p), p);
    repeat (11) @(negedge clk);
    #1 rst_n = 1'b0;
    tc_vld = 1'b0;
    exp_q.delete();
    #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done: got %b want 0", done); end
    n_chk++; if (plaintext !== '0) begin n_fail++; $display("FAIL mid_rst_pt: got %h want 0", plaintext); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(K_C1, CT_C1, PT_C1);
    wait_done(lat);
    e = exp_q.pop_front();
    n_chk++; if (done !== 1'b1 || lat != e.lat) begin n_fail++; $display("FAIL mid_lat: got %0d want %0d", lat, e.lat); end
    n_chk++; if (plaintext !== e.pt) begin n_fail++; $display("FAIL mid_pt: got %h want %h", plaintext, e.pt); end
  endtask

  task automatic test_keycache();
    exp_t e;
    int lat;
    logic [127:0] ks [3];
    logic [127:0] cs [3];
    logic [127:0] ps [3];
    ks = '{K_C1, K_C1, K_B};
    cs = '{CT_C1, CT_C1, CT_B};
    ps = '{PT_C1, PT_C1, PT_B};
    @(negedge clk);
    rst_n = 1'b0;
    tc_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      start_op(ks[i], cs[i], ps[i]);
      wait_done(lat);
      e = exp_q.pop_front();
      n_chk++; if (done !== 1'b1 || lat != e.lat) begin n_fail++; $display("FAIL kc_lat%0d: got %0d want %0d", i, lat, e.lat); end
      n_chk++; if (plaintext !== e.pt) begin n_fail++; $display("FAIL kc_pt%0d: got %h want %h", i, plaintext, e.pt); end
      @(negedge clk);
    end
  endtask

  task automatic test_roundtrip();
    exp_t e;
    int lat;
    logic [127:0] k, p;
    for (int i = 0; i < 100; i++) begin
      k = rnd128();
      p = rnd128();
      start_op(k, aes_enc(k, p), p);
      wait_done(lat);
      e = exp_q.pop_front();
      n_chk++; if (done !== 1'b1 || lat != e.lat) begin n_fail++; $display("FAIL rt_lat%0d: got %0d want %0d", i, lat, e.lat); end
      n_chk++; if (plaintext !== e.pt) begin n_fail++; $display("FAIL rt_pt%0d: got %h want %h", i, plaintext, e.pt); end
      @(negedge clk);
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_vector("c1", K_C1, CT_C1, PT_C1, RK10_C1);
    test_vector("appb", K_B, CT_B, PT_B, RK10_B);
    test_handshake();
    test_reset_mid();
    test_keycache();
    test_roundtrip();
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_empty: %0d left want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
